arbi_rr4: RTL and testbench
===========================

ARBI_RR4 -- requirements
Module: arbi_rr4

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each data input and of arb_out.
REQ-002 Parameter BURST_LEN, default 4, range 1..16, maximum beats granted per tenure.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_in  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 req_0..req_3  input  1 each  request from requester k; data_ink is valid while asserted.
REQ-006 data_in0..data_in3  input  DATA_WIDTH each  requester payload.
REQ-007 out_ready  input  1  downstream accepts arb_out when high with arb_valid.
REQ-008 grant_0..grant_3  output  1 each  registered, at most one high per cycle.
REQ-009 arb_out  output  DATA_WIDTH  registered payload of the last accepted beat.
REQ-010 arb_valid  output  1  arb_out holds an unconsumed beat.
REQ-011 arb_id  output  2  index of the requester that produced arb_out.

Function
REQ-012 The block SHALL implement two states: IDLE (no grant high) and GRANT (exactly one grant_k high).
REQ-013 stall SHALL be defined as arb_valid & !out_ready; when stall is high, arb_out, arb_valid, arb_id, grant_*, the beat counter and the state SHALL hold.
REQ-014 In IDLE with any req_k high and no stall, the block SHALL select a winner by round-robin starting at (last_winner+1) mod 4, then assert that grant on the next edge and enter GRANT.
REQ-015 A beat SHALL occur in a cycle where grant_k & req_k & !stall; on the next edge, arb_out<=data_ink, arb_id<=k, arb_valid<=1, beat counter increments.
REQ-016 In a non-stalled cycle without a beat, arb_valid SHALL go to 0 on the next edge.
REQ-017 The tenure SHALL end in a non-stalled cycle when req_k is low (no beat that cycle) or when the beat taken that cycle is the BURST_LEN-th.
REQ-018 At tenure end, last_winner<=k, beat counter<=0, and the next winner SHALL be selected in the same cycle by round-robin from (k+1) mod 4, with k itself considered last.
REQ-019 If a next winner exists, its grant SHALL be high on the next edge with no idle cycle; otherwise, the block SHALL enter IDLE with all grants low.
REQ-020 Latency: req in IDLE at cycle N -> grant at N+1 -> arb_valid at N+2 (no stall); steady-state throughput SHALL be one beat per cycle.
REQ-021 Requests from non-granted requesters SHALL NOT affect the current tenure.
REQ-022 With a single requester continuously active, the block SHALL re-grant it back-to-back after each BURST_LEN burst.
REQ-023 arb_out SHALL remain stable while stall is high; no beat SHALL be lost or duplicated.

Reset
REQ-024 With rst_in high at an edge, the block SHALL set: state IDLE, all grant_* 0, arb_valid 0, arb_out 0, arb_id 0, beat counter 0, last_winner 3, so that requester 0 has top priority.
REQ-025 Reset mid-tenure or mid-stall SHALL discard the pending beat; the first grant after reset SHALL follow REQ-014.

Verification
REQ-026 After reset, req_0..3 high, out_ready=1, BURST_LEN=4 -> grants 0,1,2,3,0..., each for 4 beats, with no gap cycles and arb_id matching.
REQ-027 Only req_2 high, out_ready=1 -> grant_2 continuous; arb_valid continuous from cycle 2 after request; all data_in2 values appear in order.
REQ-028 req_1 granted, out_ready low for 3 cycles after the second beat -> arb_out/arb_id/grant_1 frozen for 3 cycles; beat 3 follows with no loss or duplication.
REQ-029 req_0 drops after 2 beats while req_3 is high -> grant_3 on the next cycle; arb_valid low for exactly one cycle.
REQ-030 rst_in pulsed mid-burst with arb_valid=1 and out_ready=0 -> all outputs 0 at the next edge; with all requests high afterwards, grant_0 comes first.
REQ-031 Random req/out_ready for at least 10k cycles -> at most one grant high; the scoreboard matches every accepted beat to its source; no requester waits more than 3*BURST_LEN+3 cycles.

Source files
------------

// File: rtl/arbi_rr4_if.sv
// Bundle of the four requester ports, downstream handshake and grant outputs of arbi_rr4.
// The slave modport is the arbiter's view; master is the requester/downstream side.
interface arbi_rr4_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_0, req_1, req_2, req_3;
  logic [DATA_WIDTH-1:0] data_in0, data_in1, data_in2, data_in3;
  logic                  out_ready;
  logic                  grant_0, grant_1, grant_2, grant_3;
  logic [DATA_WIDTH-1:0] arb_out;
  logic                  arb_valid;
  logic [1:0]            arb_id;

  modport slave (
    input  req_0, req_1, req_2, req_3,
    input  data_in0, data_in1, data_in2, data_in3,
    input  out_ready,
    output grant_0, grant_1, grant_2, grant_3,
    output arb_out, arb_valid, arb_id
  );

  modport master (
    output req_0, req_1, req_2, req_3,
    output data_in0, data_in1, data_in2, data_in3,
    output out_ready,
    input  grant_0, grant_1, grant_2, grant_3,
    input  arb_out, arb_valid, arb_id
  );
endinterface

// File: rtl/arbi_rr4.sv
// Four-way round-robin burst arbiter: each tenure carries up to BURST_LEN beats into a
// single registered output stage that freezes while downstream back-pressures.
module arbi_rr4 #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4
) (
  input  logic      clk,
  input  logic      rst_in,
  arbi_rr4_if.slave bus
);
  localparam int CW = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                     r_state, w_state_nxt;
  logic [1:0]                 r_gidx, w_gidx_nxt;
  logic [1:0]                 r_last, w_last_nxt;
  logic [1:0]                 r_id, w_id_nxt;
  logic [3:0]                 r_grant, w_grant_nxt;
  logic [CW-1:0]              r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0]      r_out, w_out_nxt;
  logic                       r_valid, w_valid_nxt;
  logic [3:0]                 w_req;
  logic [3:0][DATA_WIDTH-1:0] w_data;
  logic                       w_stall, w_beat, w_end;
  logic [2:0]                 w_pick_idle, w_pick_end;

  // {found, index}: first requester after 'last', with 'last' itself checked at the end
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] c;
    res = 3'b000;
    for (int i = 1; i <= 4; i++) begin
      c = last + 2'(i);
      if (!res[2] && req[c]) res = {1'b1, c};
    end
    return res;
  endfunction

  assign w_req  = {bus.req_3, bus.req_2, bus.req_1, bus.req_0};
  assign w_data = {bus.data_in3, bus.data_in2, bus.data_in1, bus.data_in0};

  assign w_stall     = r_valid & ~bus.out_ready;
  assign w_beat      = (r_state == GRANT) & w_req[r_gidx] & ~w_stall;
  assign w_end       = (r_state == GRANT) & ~w_stall &
                       (~w_req[r_gidx] | (w_beat & (r_cnt == CW'(BURST_LEN - 1))));
  assign w_pick_idle = rr_pick(w_req, r_last);
  assign w_pick_end  = rr_pick(w_req, r_gidx);

  always_comb begin
    w_state_nxt = r_state;
    w_gidx_nxt  = r_gidx;
    w_last_nxt  = r_last;
    w_grant_nxt = r_grant;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_out;
    w_valid_nxt = r_valid;
    w_id_nxt    = r_id;
    if (!w_stall) begin
      w_valid_nxt = w_beat;
      if (w_beat) begin
        w_out_nxt = w_data[r_gidx];
        w_id_nxt  = r_gidx;
        w_cnt_nxt = r_cnt + CW'(1);
      end
      case (r_state)
        IDLE: begin
          if (w_pick_idle[2]) begin
            w_state_nxt = GRANT;
            w_gidx_nxt  = w_pick_idle[1:0];
            w_grant_nxt = 4'b0001 << w_pick_idle[1:0];
            w_cnt_nxt   = '0;
          end
        end
        GRANT: begin
          if (w_end) begin
            w_last_nxt = r_gidx;
            w_cnt_nxt  = '0;
            // hand over without a bubble when someone is waiting
            if (w_pick_end[2]) begin
              w_gidx_nxt  = w_pick_end[1:0];
              w_grant_nxt = 4'b0001 << w_pick_end[1:0];
            end else begin
              w_state_nxt = IDLE;
              w_grant_nxt = 4'b0000;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_gidx  <= 2'd0;
      r_last  <= 2'd3;
      r_grant <= 4'b0000;
      r_cnt   <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_id    <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_gidx  <= w_gidx_nxt;
      r_last  <= w_last_nxt;
      r_grant <= w_grant_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
      r_valid <= w_valid_nxt;
      r_id    <= w_id_nxt;
    end
  end

  assign bus.grant_0   = r_grant[0];
  assign bus.grant_1   = r_grant[1];
  assign bus.grant_2   = r_grant[2];
  assign bus.grant_3   = r_grant[3];
  assign bus.arb_out   = r_out;
  assign bus.arb_valid = r_valid;
  assign bus.arb_id    = r_id;
endmodule

// File: tb/tb_arbi_rr4.sv
// Directed and randomized checks of arbi_rr4 with BURST_LEN=4; inputs change 1ns after
// each rising edge and outputs are sampled there too.
module tb_arbi_rr4;
  localparam int DW  = 32;
  localparam int BL  = 4;
  localparam int LIM = 3 * BL + 3;

  logic clk = 1'b0;
  logic rst_in;
  int   checks   = 0;
  int   failures = 0;

  arbi_rr4_if #(.DATA_WIDTH(DW)) bus ();
  arbi_rr4 #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (.clk(clk), .rst_in(rst_in), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [3:0] gnt();
    return {bus.grant_3, bus.grant_2, bus.grant_1, bus.grant_0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] r);
    bus.req_0 = r[0]; bus.req_1 = r[1]; bus.req_2 = r[2]; bus.req_3 = r[3];
  endtask

  task automatic set_data(input int k, input logic [DW-1:0] d);
    case (k)
      0: bus.data_in0 = d;
      1: bus.data_in1 = d;
      2: bus.data_in2 = d;
      default: bus.data_in3 = d;
    endcase
  endtask

  task automatic do_reset();
    set_req(4'b0000);
    bus.out_ready = 1'b1;
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (gnt() !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", gnt()); end
    checks++; if (bus.arb_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.arb_valid); end
    checks++; if (bus.arb_out !== 32'd0) begin failures++; $display("FAIL reset_out got=%h exp=0", bus.arb_out); end
    checks++; if (bus.arb_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", bus.arb_id); end
    tick();
    checks++; if (gnt() !== 4'b0000 || bus.arb_valid !== 1'b0) begin
      failures++; $display("FAIL idle_no_req grant=%b valid=%b exp 0000/0", gnt(), bus.arb_valid);
    end
  endtask

  task automatic test_all_req();
    logic [3:0] exp_g;
    logic [1:0] exp_id;
    do_reset();
    for (int k = 0; k < 4; k++) set_data(k, 32'hD0 + 32'(k));
    set_req(4'b1111);
    for (int s = 0; s < 20; s++) begin
      tick();
      exp_g = 4'b0001 << ((s / 4) % 4);
      checks++; if (gnt() !== exp_g) begin failures++; $display("FAIL all_req_grant s=%0d got=%b exp=%b", s, gnt(), exp_g); end
      if (s == 0) begin
        checks++; if (bus.arb_valid !== 1'b0) begin failures++; $display("FAIL all_req_latency got=%b exp=0", bus.arb_valid); end
      end else begin
        exp_id = 2'(((s - 1) / 4) % 4);
        checks++;
        if (bus.arb_valid !== 1'b1 || bus.arb_id !== exp_id || bus.arb_out !== 32'hD0 + 32'(exp_id)) begin
          failures++;
          $display("FAIL all_req_beat s=%0d got v=%b id=%0d out=%h exp v=1 id=%0d out=%h",
                   s, bus.arb_valid, bus.arb_id, bus.arb_out, exp_id, 32'hD0 + 32'(exp_id));
        end
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    set_data(2, 32'd200);
    set_req(4'b0100);
    for (int s = 0; s < 12; s++) begin
      tick();
      checks++; if (gnt() !== 4'b0100) begin failures++; $display("FAIL single_grant s=%0d got=%b exp=0100", s, gnt()); end
      if (s == 0) begin
        checks++; if (bus.arb_valid !== 1'b0) begin failures++; $display("FAIL single_latency got=%b exp=0", bus.arb_valid); end
      end else begin
        checks++;
        if (bus.arb_valid !== 1'b1 || bus.arb_id !== 2'd2 || bus.arb_out !== 32'(200 + s)) begin
          failures++;
          $display("FAIL single_beat s=%0d got v=%b id=%0d out=%0d exp v=1 id=2 out=%0d",
                   s, bus.arb_valid, bus.arb_id, bus.arb_out, 200 + s);
        end
      end
      set_data(2, 32'(200 + s + 1));
    end
  endtask

  task automatic test_stall();
    int exp_out [9];
    exp_out = '{0, 301, 302, 302, 302, 302, 303, 304, 305};
    do_reset();
    set_data(1, 32'd301);
    set_req(4'b0010);
    for (int s = 0; s < 9; s++) begin
      tick();
      checks++; if (gnt() !== 4'b0010) begin failures++; $display("FAIL stall_grant s=%0d got=%b exp=0010", s, gnt()); end
      checks++;
      if (s == 0) begin
        if (bus.arb_valid !== 1'b0) begin failures++; $display("FAIL stall_first_valid got=%b exp=0", bus.arb_valid); end
      end else if (bus.arb_valid !== 1'b1 || bus.arb_id !== 2'd1 || bus.arb_out !== 32'(exp_out[s])) begin
        failures++;
        $display("FAIL stall_beat s=%0d got v=%b id=%0d out=%0d exp v=1 id=1 out=%0d",
                 s, bus.arb_valid, bus.arb_id, bus.arb_out, exp_out[s]);
      end
      case (s)
        1: set_data(1, 32'd302);
        2: begin set_data(1, 32'd303); bus.out_ready = 1'b0; end
        5: bus.out_ready = 1'b1;
        6: set_data(1, 32'd304);
        7: set_data(1, 32'd305);
        default: ;
      endcase
    end
  endtask

  task automatic test_drop();
    do_reset();
    set_data(0, 32'h500);
    set_data(3, 32'h533);
    set_req(4'b1001);
    tick();
    checks++; if (gnt() !== 4'b0001) begin failures++; $display("FAIL drop_first_grant got=%b exp=0001", gnt()); end
    tick();
    tick();
    checks++; if (gnt() !== 4'b0001 || bus.arb_valid !== 1'b1 || bus.arb_id !== 2'd0) begin
      failures++; $display("FAIL drop_two_beats grant=%b v=%b id=%0d exp 0001/1/0", gnt(), bus.arb_valid, bus.arb_id);
    end
    set_req(4'b1000);
    tick();
    checks++; if (gnt() !== 4'b1000) begin failures++; $display("FAIL drop_handover got=%b exp=1000", gnt()); end
    checks++; if (bus.arb_valid !== 1'b0) begin failures++; $display("FAIL drop_gap got=%b exp=0", bus.arb_valid); end
    tick();
    checks++; if (bus.arb_valid !== 1'b1 || bus.arb_id !== 2'd3 || bus.arb_out !== 32'h533) begin
      failures++; $display("FAIL drop_new_beat v=%b id=%0d out=%h exp 1/3/533", bus.arb_valid, bus.arb_id, bus.arb_out);
    end
    tick();
    checks++; if (bus.arb_valid !== 1'b1) begin failures++; $display("FAIL drop_gap_len got=%b exp=1", bus.arb_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 4; k++) set_data(k, 32'hE0 + 32'(k));
    set_req(4'b1111);
    for (int s = 0; s < 6; s++) begin
      tick();
      if (s == 5) bus.out_ready = 1'b0;
    end
    tick();
    checks++; if (gnt() !== 4'b0010 || bus.arb_valid !== 1'b1 || bus.arb_out !== 32'hE1) begin
      failures++; $display("FAIL rmid_pre grant=%b v=%b out=%h exp 0010/1/e1", gnt(), bus.arb_valid, bus.arb_out);
    end
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    bus.out_ready = 1'b1;
    checks++; if (gnt() !== 4'b0000 || bus.arb_valid !== 1'b0 || bus.arb_out !== 32'd0 || bus.arb_id !== 2'd0) begin
      failures++; $display("FAIL rmid_clear grant=%b v=%b out=%h id=%0d exp all 0", gnt(), bus.arb_valid, bus.arb_out, bus.arb_id);
    end
    tick();
    checks++; if (gnt() !== 4'b0001 || bus.arb_valid !== 1'b0) begin
      failures++; $display("FAIL rmid_first grant=%b v=%b exp 0001/0", gnt(), bus.arb_valid);
    end
  endtask

  task automatic test_random();
    int         seq [4];
    int         wt  [4];
    logic [3:0] r, g, g_now;
    logic       cur_stall;
    logic [DW-1:0] held_out;
    logic [1:0] held_id, bk;
    logic       beat;
    do_reset();
    r = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      seq[k] = 0; wt[k] = 0;
      set_data(k, (32'(k) << 24));
    end
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < 4; k++) if (!r[k] && $urandom_range(3) == 0) r[k] = 1'b1;
      set_req(r);
      bus.out_ready = ($urandom_range(3) != 0);
      cur_stall = bus.arb_valid & ~bus.out_ready;
      g_now     = gnt();
      held_out  = bus.arb_out;
      held_id   = bus.arb_id;
      tick();
      g = gnt();
      beat = 1'b0; bk = 2'd0;
      for (int k = 0; k < 4; k++) if (!cur_stall && g_now[k] && r[k]) begin beat = 1'b1; bk = 2'(k); end
      checks++; if ($countones(g) > 1) begin failures++; $display("FAIL rnd_onehot c=%0d got=%b exp<=1 hot", c, g); end
      checks++;
      if (cur_stall) begin
        if (bus.arb_valid !== 1'b1 || bus.arb_out !== held_out || bus.arb_id !== held_id || g !== g_now) begin
          failures++;
          $display("FAIL rnd_stall c=%0d got v=%b out=%h id=%0d g=%b exp v=1 out=%h id=%0d g=%b",
                   c, bus.arb_valid, bus.arb_out, bus.arb_id, g, held_out, held_id, g_now);
        end
      end else if (beat) begin
        if (bus.arb_valid !== 1'b1 || bus.arb_id !== bk || bus.arb_out !== ((32'(bk) << 24) | 32'(seq[bk]))) begin
          failures++;
          $display("FAIL rnd_beat c=%0d got v=%b id=%0d out=%h exp v=1 id=%0d out=%h",
                   c, bus.arb_valid, bus.arb_id, bus.arb_out, bk, (32'(bk) << 24) | 32'(seq[bk]));
        end
        seq[bk]++;
        set_data(int'(bk), (32'(bk) << 24) | 32'(seq[bk]));
        if ($urandom_range(3) == 0) r[bk] = 1'b0;
      end else if (bus.arb_valid !== 1'b0) begin
        failures++; $display("FAIL rnd_nobeat c=%0d got v=%b exp=0", c, bus.arb_valid);
      end
      for (int k = 0; k < 4; k++) begin
        if (g[k] || !r[k]) wt[k] = 0;
        else if (!cur_stall) wt[k]++;
        checks++;
        if (wt[k] > LIM) begin failures++; $display("FAIL rnd_wait c=%0d req=%0d waited=%0d limit=%0d", c, k, wt[k], LIM); end
      end
    end
    set_req(4'b0000);
    bus.out_ready = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    rst_in = 1'b0;
    bus.out_ready = 1'b1;
    set_req(4'b0000);
    for (int k = 0; k < 4; k++) set_data(k, '0);
    test_reset();
    test_all_req();
    test_single();
    test_stall();
    test_drop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
